// File: rtl/md_sequencer.sv
// ----------------------------------------------------------------------------
// md_sequencer
// Control sequencer for an iterative multiply/divide unit. It accepts a start
// request in IDLE, loads the operands, steps the unit ITER times, writes HI/LO,
// and then pulses done. A divide by a zero divisor takes a short exception path
// that pulses Div0 instead. flush aborts any operation on the next edge.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module md_sequencer #(
    parameter int ITER = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic       divisor_zero,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output logic       Div0,
    output logic       md_init,
    output logic       md_step,
    output logic       MDcontrol,
    output logic       HILOWrite,
    output logic [5:0] count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_EXC   = 3'd5
    } state_t;

    // Index of the final iteration; count stops here rather than wrapping.
    localparam logic [5:0] LAST_IDX = 6'(ITER - 1);

    state_t     state_q, state_d;
    logic       mdc_q,   mdc_d;
    logic [5:0] count_q, count_d;

    // State, latched operation and iteration index registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mdc_q   <= 1'b0;
            count_q <= 6'd0;
        end else begin
            state_q <= state_d;
            mdc_q   <= mdc_d;
            count_q <= count_d;
        end
    end

    // Next-state and Moore outputs; flush blocks all state updates and gates
    // the completion/exception pulses of the current cycle.
    always_comb begin
        state_d   = state_q;
        mdc_d     = mdc_q;
        count_d   = count_q;
        md_init   = 1'b0;
        md_step   = 1'b0;
        HILOWrite = 1'b0;
        done      = 1'b0;
        Div0      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    mdc_d   = op;
                    state_d = (op && divisor_zero) ? S_EXC : S_INIT;
                end
            end
            S_INIT: begin
                md_init = 1'b1;
                if (!flush) begin
                    count_d = 6'd0;
                end
                state_d = S_RUN;
            end
            S_RUN: begin
                md_step = 1'b1;
                if (count_q == LAST_IDX) begin
                    state_d = S_WRITE;
                end else if (!flush) begin
                    count_d = count_q + 6'd1;
                end
            end
            S_WRITE: begin
                HILOWrite = !flush;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = !flush;
                state_d = S_IDLE;
            end
            S_EXC: begin
                Div0    = !flush;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign MDcontrol = mdc_q;
    assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// ----------------------------------------------------------------------------
// tb_md_sequencer
// Drives two sequencers (ITER=32 and ITER=4) with shared directed and random
// stimulus. A timeline model predicts per-cycle outputs; done/Div0 pulses are
// matched against a scoreboard queue filled when a start is accepted.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_md_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic       divisor_zero = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] busy, done, Div0, md_init, md_step, MDcontrol, HILOWrite;
    logic [5:0] count0, count1;

    logic [10:0] obs     [2];
    logic [10:0] exp_vec [2];

    typedef struct {
        int dut;
        bit kind;   // 1 = Div0 expected, 0 = done expected
        int pcyc;
        bit mdctl;
    } rec_t;

    rec_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Model state per instance: operation timeline anchored at its start cycle.
    bit act  [2];
    bit exc  [2];
    int c0   [2];
    int held [2];
    bit mdl  [2];

    md_sequencer #(.ITER(32)) u_dut0 (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .divisor_zero(divisor_zero), .flush(flush), .busy(busy[0]),
        .done(done[0]), .Div0(Div0[0]), .md_init(md_init[0]),
        .md_step(md_step[0]), .MDcontrol(MDcontrol[0]),
        .HILOWrite(HILOWrite[0]), .count(count0)
    );

    md_sequencer #(.ITER(4)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .divisor_zero(divisor_zero), .flush(flush), .busy(busy[1]),
        .done(done[1]), .Div0(Div0[1]), .md_init(md_init[1]),
        .md_step(md_step[1]), .MDcontrol(MDcontrol[1]),
        .HILOWrite(HILOWrite[1]), .count(count1)
    );

    assign obs[0] = {busy[0], md_init[0], md_step[0], HILOWrite[0], MDcontrol[0], count0};
    assign obs[1] = {busy[1], md_init[1], md_step[1], HILOWrite[1], MDcontrol[1], count1};

    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int iter_of(input int k);
        return (k == 0) ? 32 : 4;
    endfunction

    // One clock cycle of stimulus: apply inputs, predict this cycle's outputs,
    // then advance the model (abort on flush, accept a start when idle).
    task automatic step(input bit st, input bit o, input bit dz, input bit fl, input bit do_rst);
        int d, it, v;
        bit b, i, s, h;
        logic [5:0] cn;
        @(posedge clock);
        #1;
        start = st; op = o; divisor_zero = dz; flush = fl;
        for (int k = 0; k < 2; k++) begin
            it = iter_of(k);
            if (act[k]) begin
                if (!exc[k] && cyc >= c0[k] + 4 + it) begin
                    act[k]  = 1'b0;
                    held[k] = it - 1;
                end else if (exc[k] && cyc >= c0[k] + 2) begin
                    act[k] = 1'b0;
                end
            end
            b = 0; i = 0; s = 0; h = 0;
            cn = 6'(held[k]);
            if (act[k]) begin
                d = cyc - c0[k];
                b = 1;
                if (!exc[k]) begin
                    i = (d == 1);
                    s = (d >= 2) && (d <= 1 + it);
                    h = (d == 2 + it) && !fl;
                    if (d >= 2) begin
                        v = d - 2;
                        if (v > it - 1) v = it - 1;
                        cn = 6'(v);
                    end
                end
            end
            exp_vec[k] = {b, i, s, h, mdl[k], cn};
            if (act[k] && fl) begin
                held[k] = int'(cn);
                act[k]  = 1'b0;
                for (int j = sbq.size() - 1; j >= 0; j--) begin
                    if (sbq[j].dut == k) begin
                        sbq.delete(j);
                        break;
                    end
                end
            end else if (!act[k] && st && !fl) begin
                act[k] = 1'b1;
                c0[k]  = cyc;
                exc[k] = o && dz;
                mdl[k] = o;
                sbq.push_back('{dut: k, kind: o && dz,
                                pcyc: (o && dz) ? cyc + 1 : cyc + 3 + it, mdctl: o});
            end
        end
        if (do_rst) begin
            #2;
            reset = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({obs[k], done[k], Div0[k]} !== 13'd0) begin
                    errors++;
                    $display("FAIL async_reset dut%0d cyc %0d: got %b expected all zero",
                             k, cyc, {obs[k], done[k], Div0[k]});
                end
                act[k] = 0; held[k] = 0; mdl[k] = 0;
                exp_vec[k] = 11'd0;
            end
            sbq.delete();
            #2;
            reset = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0);
    endtask

    // Per-cycle output comparison plus scoreboard matching of done/Div0 pulses.
    always @(negedge clock) begin
        int idx;
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL outputs dut%0d cyc %0d: got busy,init,step,hilo,mdc,count=%b expected %b",
                             k, cyc, obs[k], exp_vec[k]);
                end
                checks++;
                if ($countones({md_init[k], md_step[k], HILOWrite[k], done[k], Div0[k]}) > 1) begin
                    errors++;
                    $display("FAIL exclusive dut%0d cyc %0d: got %b expected at most one pulse",
                             k, cyc, {md_init[k], md_step[k], HILOWrite[k], done[k], Div0[k]});
                end
                for (int j = sbq.size() - 1; j >= 0; j--) begin
                    if (sbq[j].dut == k && sbq[j].pcyc < cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_pulse dut%0d cyc %0d: got none expected %s at cyc %0d",
                                 k, cyc, sbq[j].kind ? "Div0" : "done", sbq[j].pcyc);
                        sbq.delete(j);
                    end
                end
                if (done[k] || Div0[k]) begin
                    idx = -1;
                    for (int j = 0; j < sbq.size(); j++) begin
                        if (idx < 0 && sbq[j].dut == k) idx = j;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse dut%0d cyc %0d: got done=%b Div0=%b expected none",
                                 k, cyc, done[k], Div0[k]);
                    end else begin
                        if (sbq[idx].kind != Div0[k] || sbq[idx].pcyc != cyc ||
                            sbq[idx].mdctl != MDcontrol[k]) begin
                            errors++;
                            $display("FAIL pulse dut%0d: got Div0=%b cyc=%0d mdc=%b expected Div0=%b cyc=%0d mdc=%b",
                                     k, Div0[k], cyc, MDcontrol[k], sbq[idx].kind, sbq[idx].pcyc, sbq[idx].mdctl);
                        end
                        sbq.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; exc[k] = 0; c0[k] = 0; held[k] = 0; mdl[k] = 0;
            exp_vec[k] = 11'd0;
        end
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({obs[k], done[k], Div0[k]} !== 13'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %b expected all zero", k, {obs[k], done[k], Div0[k]});
            end
        end
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        mon_en = 1'b1;

        // Multiply
        step(1, 0, 0, 0, 0); idle(40);
        // Divide by zero
        step(1, 1, 1, 0, 0); idle(5);
        // Normal divide with an extra start ten cycles later
        step(1, 1, 0, 0, 0); idle(9); step(1, 0, 0, 0, 0); idle(40);
        // Flush at RUN count 15, then a fresh operation
        step(1, 0, 0, 0, 0); idle(16); step(0, 0, 0, 1, 0); idle(3);
        step(1, 0, 0, 0, 0); idle(40);
        // Asynchronous reset at RUN count 20, then a fresh operation
        step(1, 1, 0, 0, 0); idle(21); step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0); idle(40);
        // Back-to-back starts
        step(1, 0, 0, 0, 0); idle(35); step(1, 1, 0, 0, 0); idle(40);
        // Start together with flush in IDLE
        step(1, 0, 0, 1, 0); idle(3);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0)
                step(0, 0, 0, 0, 1);
            else
                step($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                     $urandom_range(0, 63) == 0, 0);
        end
        idle(45);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending expected 0", sbq.size());
        end
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
